ibex_obi_axi_master_bridge: RTL

- Converts one Ibex OBI-style memory port (instruction or data) into an AXI4 master.
- Each OBI request becomes a single-beat AXI4 transaction, one outstanding at a time.
- Sits directly upstream of the M00/M01 AXI master ports of the Ibex AXI IP; one instance per port.

---
 rtl/ibex_obi_axi_master_bridge_if.sv | 66 ++++++
 rtl/ibex_obi_axi_master_bridge.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ibex_obi_axi_master_bridge_if.sv
// AXI4 master-port bundle used by the Ibex OBI-to-AXI bridge.
// Single-beat, 32-bit data and address; the bridge takes the master side.
interface ibex_obi_axi_master_bridge_if;
    logic [31:0] m00_axi_awaddr;
    logic        m00_axi_awid;
    logic [7:0]  m00_axi_awlen;
    logic [2:0]  m00_axi_awsize;
    logic [1:0]  m00_axi_awburst;
    logic        m00_axi_awlock;
    logic [3:0]  m00_axi_awcache;
    logic [2:0]  m00_axi_awprot;
    logic [3:0]  m00_axi_awqos;
    logic        m00_axi_awvalid;
    logic        m00_axi_awready;

    logic [31:0] m00_axi_wdata;
    logic [3:0]  m00_axi_wstrb;
    logic        m00_axi_wlast;
    logic        m00_axi_wvalid;
    logic        m00_axi_wready;

    logic [1:0]  m00_axi_bresp;
    logic        m00_axi_bvalid;
    logic        m00_axi_bready;

    logic [31:0] m00_axi_araddr;
    logic        m00_axi_arid;
    logic [7:0]  m00_axi_arlen;
    logic [2:0]  m00_axi_arsize;
    logic [1:0]  m00_axi_arburst;
    logic        m00_axi_arlock;
    logic [3:0]  m00_axi_arcache;
    logic [2:0]  m00_axi_arprot;
    logic [3:0]  m00_axi_arqos;
    logic        m00_axi_arvalid;
    logic        m00_axi_arready;

    logic [31:0] m00_axi_rdata;
    logic [1:0]  m00_axi_rresp;
    logic        m00_axi_rvalid;
    logic        m00_axi_rready;

    modport master (
        output m00_axi_awaddr, m00_axi_awid, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
               m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos, m00_axi_awvalid,
               m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast, m00_axi_wvalid,
               m00_axi_bready,
               m00_axi_araddr, m00_axi_arid, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
               m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos, m00_axi_arvalid,
               m00_axi_rready,
        input  m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
               m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid
    );

    modport slave (
        input  m00_axi_awaddr, m00_axi_awid, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
               m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos, m00_axi_awvalid,
               m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast, m00_axi_wvalid,
               m00_axi_bready,
               m00_axi_araddr, m00_axi_arid, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
               m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos, m00_axi_arvalid,
               m00_axi_rready,
        output m00_axi_awready, m00_axi_wready, m00_axi_bresp, m00_axi_bvalid,
               m00_axi_arready, m00_axi_rdata, m00_axi_rresp, m00_axi_rvalid
    );
endinterface

// File: rtl/ibex_obi_axi_master_bridge.sv
// Converts one Ibex OBI memory port into an AXI4 master issuing single-beat
// transactions, one outstanding at a time.
module ibex_obi_axi_master_bridge #(
    parameter logic       AXI_ID  = 1'b0,
    parameter logic [2:0] AXPROT  = 3'b000,
    parameter logic [3:0] AXCACHE = 4'b0011
) (
    input  logic        m00_axi_aclk,
    input  logic        m00_axi_aresetn,

    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,

    ibex_obi_axi_master_bridge_if.master m00_axi
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_D = 3'd2,
        S_WR   = 3'd3,
        S_WR_B = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic        gnt_s;
    logic        arvalid_s;
    logic        awvalid_s;
    logic        wvalid_s;
    logic        rready_s;
    logic        bready_s;

    // Only resp[1] separates OKAY/EXOKAY from SLVERR/DECERR; addr_i[1:0] is dropped on purpose.
    logic        unused_s;
    assign unused_s = ^{addr_i[1:0], m00_axi.m00_axi_rresp[0], m00_axi.m00_axi_bresp[0]};

    // State, request latch and registered OBI response.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_q   <= S_IDLE;
            addr_q    <= 32'h0000_0000;
            be_q      <= 4'b0000;
            wdata_q   <= 32'h0000_0000;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and channel control for the single-outstanding transaction FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        gnt_s     = 1'b0;
        arvalid_s = 1'b0;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        rready_s  = 1'b0;
        bready_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Grant is combinational so a new request can be taken in the response cycle.
                gnt_s = req_i;
                if (req_i) begin
                    addr_d    = {addr_i[31:2], 2'b00};
                    be_d      = be_i;
                    wdata_d   = wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (we_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD_A;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RD_A: begin
                arvalid_s = 1'b1;
                if (m00_axi.m00_axi_arready) begin
                    state_d = S_RD_D;
                end else begin
                    state_d = S_RD_A;
                end
            end

            S_RD_D: begin
                rready_s = 1'b1;
                if (m00_axi.m00_axi_rvalid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = m00_axi.m00_axi_rdata;
                    err_d    = m00_axi.m00_axi_rresp[1];
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_RD_D;
                end
            end

            S_WR: begin
                // AW and W complete independently; each valid drops after its own handshake.
                awvalid_s = ~aw_done_q;
                wvalid_s  = ~w_done_q;
                aw_done_d = aw_done_q | (awvalid_s & m00_axi.m00_axi_awready);
                w_done_d  = w_done_q | (wvalid_s & m00_axi.m00_axi_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = S_WR_B;
                end else begin
                    state_d = S_WR;
                end
            end

            S_WR_B: begin
                bready_s = 1'b1;
                if (m00_axi.m00_axi_bvalid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0000_0000;
                    err_d    = m00_axi.m00_axi_bresp[1];
                    state_d  = S_IDLE;
                end else begin
                    state_d  = S_WR_B;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign gnt_o    = gnt_s;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign m00_axi.m00_axi_awaddr  = addr_q;
    assign m00_axi.m00_axi_awid    = AXI_ID;
    assign m00_axi.m00_axi_awlen   = 8'h00;
    assign m00_axi.m00_axi_awsize  = 3'b010;
    assign m00_axi.m00_axi_awburst = 2'b01;
    assign m00_axi.m00_axi_awlock  = 1'b0;
    assign m00_axi.m00_axi_awcache = AXCACHE;
    assign m00_axi.m00_axi_awprot  = AXPROT;
    assign m00_axi.m00_axi_awqos   = 4'h0;
    assign m00_axi.m00_axi_awvalid = awvalid_s;

    assign m00_axi.m00_axi_wdata   = wdata_q;
    assign m00_axi.m00_axi_wstrb   = be_q;
    assign m00_axi.m00_axi_wlast   = 1'b1;
    assign m00_axi.m00_axi_wvalid  = wvalid_s;

    assign m00_axi.m00_axi_bready  = bready_s;

    assign m00_axi.m00_axi_araddr  = addr_q;
    assign m00_axi.m00_axi_arid    = AXI_ID;
    assign m00_axi.m00_axi_arlen   = 8'h00;
    assign m00_axi.m00_axi_arsize  = 3'b010;
    assign m00_axi.m00_axi_arburst = 2'b01;
    assign m00_axi.m00_axi_arlock  = 1'b0;
    assign m00_axi.m00_axi_arcache = AXCACHE;
    assign m00_axi.m00_axi_arprot  = AXPROT;
    assign m00_axi.m00_axi_arqos   = 4'h0;
    assign m00_axi.m00_axi_arvalid = arvalid_s;

    assign m00_axi.m00_axi_rready  = rready_s;

endmodule
